// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared types and helpers for the gate1 data-mux IJTAG TDR.
// FIREBIRD7_IN_GATE1_TDR_PARITY_EN adds an even-parity bit to the scan register.
package firebird7_in_gate1_tessent_tdr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURED = 2'd1,
        SHIFTING = 2'd2,
        OVERRUN  = 2'd3
    } tdr_state_e;

    function automatic int tdr_len(input int width);
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
        return width + 2;
`else
        return width + 1;
`endif
    endfunction

    // Callers zero-extend; zeros do not disturb the XOR.
    function automatic logic even_parity(input logic [31:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctrl.sv
// IJTAG TDR driving select/data of the gate1 3-bit data mux, with shift-length checking.
// FIREBIRD7_IN_GATE1_TDR_PARITY_EN: extra even-parity bit in SR, checked on update.
//
// state    | meaning
// IDLE     | after reset or an update attempt; no valid shift in progress
// CAPTURED | SR just loaded from functional_data_in / ijtag_select
// SHIFTING | 1..L bits shifted since capture/update
// OVERRUN  | more than L bits shifted; next update is rejected
module firebird7_in_gate1_tessent_tdr_data_ctrl
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int              WIDTH      = 3,
    parameter logic [WIDTH-1:0] DATA_RESET = '0,
    parameter logic            SEL_RESET  = 1'b0
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             update_error
);

    localparam int L     = tdr_len(WIDTH);
    localparam int CNT_W = $clog2(L + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(L + 1);

    tdr_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [L-1:0]     sr_q, sr_d;
    logic             select_q, select_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             error_q, error_d;

    logic [L-1:0] capture_word;
    logic         parity_ok;
    logic         update_req;
    logic         update_ok;

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    assign capture_word = {even_parity(32'({functional_data_in, select_q})),
                           functional_data_in, select_q};
    assign parity_ok    = (even_parity(32'(sr_q)) == 1'b0);
`else
    assign capture_word = {functional_data_in, select_q};
    assign parity_ok    = 1'b1;
`endif

    // ue only counts when neither capture nor shift claims the edge.
    assign update_req = ijtag_sel && !ijtag_ce && !ijtag_se && ijtag_ue;
    assign update_ok  = (state_q == SHIFTING) && (bit_cnt_q == CNT_FULL) && parity_ok;

    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            select_q  <= SEL_RESET;
            data_q    <= DATA_RESET;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            select_q  <= select_d;
            data_q    <= data_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr_d      = capture_word;
                bit_cnt_d = '0;
                state_d   = CAPTURED;
            end else if (ijtag_se) begin
                sr_d = {ijtag_si, sr_q[L-1:1]};
                if (bit_cnt_q != CNT_SAT) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
                state_d = (bit_cnt_q < CNT_FULL) ? SHIFTING : OVERRUN;
            end else if (ijtag_ue) begin
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        end
    end

    always_comb begin
        select_d = select_q;
        data_d   = data_q;
        error_d  = error_q;
        if (update_req) begin
            if (update_ok) begin
                select_d = sr_q[0];
                data_d   = sr_q[WIDTH:1];
                error_d  = 1'b0;
            end else begin
                error_d  = 1'b1;
            end
        end
    end

    assign ijtag_so       = sr_q[0];
    assign ijtag_select   = select_q;
    assign ijtag_data_out = data_q;
    assign update_error   = error_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_data_ctrl.sv
// Directed bench for the gate1 data-mux TDR; parity cases run when
// FIREBIRD7_IN_GATE1_TDR_PARITY_EN is defined.
module tb_firebird7_in_gate1_tessent_tdr_data_ctrl;

    localparam int L = firebird7_in_gate1_tessent_tdr_pkg::tdr_len(3);

    logic       ijtag_tck = 1'b0;
    logic       ijtag_reset = 1'b0;
    logic       ijtag_sel = 1'b0;
    logic       ijtag_ce = 1'b0;
    logic       ijtag_se = 1'b0;
    logic       ijtag_ue = 1'b0;
    logic       ijtag_si = 1'b0;
    logic       ijtag_so;
    logic [2:0] functional_data_in = 3'b000;
    logic       ijtag_select;
    logic [2:0] ijtag_data_out;
    logic       update_error;

    int n_cmp = 0;
    int n_err = 0;

    firebird7_in_gate1_tessent_tdr_data_ctrl #(
        .WIDTH      (3),
        .DATA_RESET (3'b000),
        .SEL_RESET  (1'b0)
    ) dut (
        .ijtag_tck          (ijtag_tck),
        .ijtag_reset        (ijtag_reset),
        .ijtag_sel          (ijtag_sel),
        .ijtag_ce           (ijtag_ce),
        .ijtag_se           (ijtag_se),
        .ijtag_ue           (ijtag_ue),
        .ijtag_si           (ijtag_si),
        .ijtag_so           (ijtag_so),
        .functional_data_in (functional_data_in),
        .ijtag_select       (ijtag_select),
        .ijtag_data_out     (ijtag_data_out),
        .update_error       (update_error)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ijtag_tck);
        #1;
    endtask

    task automatic do_capture(input logic [2:0] fdi);
        functional_data_in = fdi;
        ijtag_ce = 1'b1;
        tick();
        ijtag_ce = 1'b0;
    endtask

    // bits[0] is shifted first and ends up in SR[0] (select) after L shifts.
    task automatic shift_n(input logic [7:0] bits, input int n);
        ijtag_se = 1'b1;
        for (int i = 0; i < n; i++) begin
            ijtag_si = bits[i];
            tick();
        end
        ijtag_se = 1'b0;
        ijtag_si = 1'b0;
    endtask

    task automatic do_update();
        ijtag_ue = 1'b1;
        tick();
        ijtag_ue = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic sel, input logic [2:0] data, input logic err);
        chk_eq({tag, "_sel"}, 32'(ijtag_select), 32'(sel));
        chk_eq({tag, "_data"}, 32'(ijtag_data_out), 32'(data));
        chk_eq({tag, "_err"}, 32'(update_error), 32'(err));
    endtask

    logic [7:0] w;

    initial begin
        // Reset with enables toggling across two edges.
        ijtag_sel = 1'b1;
        ijtag_ce  = 1'b1;
        ijtag_si  = 1'b1;
        functional_data_in = 3'b111;
        tick();
        ijtag_ce = 1'b0;
        ijtag_se = 1'b1;
        ijtag_ue = 1'b1;
        tick();
        chk_out("reset", 1'b0, 3'b000, 1'b0);
        chk_eq("reset_so", 32'(ijtag_so), 32'd0);
        ijtag_se = 1'b0;
        ijtag_ue = 1'b0;
        ijtag_si = 1'b0;
        ijtag_reset = 1'b1;
        tick();

        // Good update: select=1, data=110 (parity bit 1).
        do_capture(3'b000);
        shift_n(8'b0001_1101, L);
        do_update();
        chk_out("good", 1'b1, 3'b110, 1'b0);

        // Capture/observe: SR = {101,1} -> so 1,1,0,1.
        do_capture(3'b101);
        chk_eq("obs0", 32'(ijtag_so), 32'd1);
        ijtag_se = 1'b1;
        tick();
        chk_eq("obs1", 32'(ijtag_so), 32'd1);
        tick();
        chk_eq("obs2", 32'(ijtag_so), 32'd0);
        tick();
        chk_eq("obs3", 32'(ijtag_so), 32'd1);
        ijtag_se = 1'b0;

        // Short shift rejected, then a correct update clears the error.
        do_capture(3'b000);
        shift_n(8'b0000_0110, L - 1);
        do_update();
        chk_out("short", 1'b1, 3'b110, 1'b1);
        do_capture(3'b000);
        shift_n(8'b0000_0110, L);
        do_update();
        chk_out("recover", 1'b0, 3'b011, 1'b0);

        // Overrun rejected.
        do_capture(3'b000);
        shift_n(8'b0001_1111, L + 1);
        do_update();
        chk_out("overrun", 1'b0, 3'b011, 1'b1);

        // ue together with se: shift only, no update attempt.
        do_capture(3'b000);
        w = 8'b0000_1001;
        shift_n(w, L - 1);
        ijtag_se = 1'b1;
        ijtag_ue = 1'b1;
        ijtag_si = w[L-1];
        tick();
        ijtag_se = 1'b0;
        ijtag_ue = 1'b0;
        ijtag_si = 1'b0;
        chk_out("se_ue", 1'b0, 3'b011, 1'b1);
        do_update();
        chk_out("after_se_ue", 1'b1, 3'b100, 1'b0);

        // Deselected: ue is ignored.
        ijtag_sel = 1'b0;
        do_update();
        chk_eq("desel_err", 32'(update_error), 32'd0);
        ijtag_sel = 1'b1;

        // ce and se together: capture wins, counter restarts at 0.
        ijtag_ce = 1'b1;
        ijtag_se = 1'b1;
        functional_data_in = 3'b010;
        tick();
        ijtag_ce = 1'b0;
        ijtag_se = 1'b0;
        chk_eq("ce_se_so", 32'(ijtag_so), 32'd1);
        shift_n(8'b0001_0010, L);
        do_update();
        chk_out("ce_se", 1'b0, 3'b001, 1'b0);

        // Reset mid-shift, then shift from IDLE without capture.
        do_capture(3'b111);
        shift_n(8'b0000_0011, 2);
        ijtag_reset = 1'b0;
        ijtag_se = 1'b1;
        tick();
        ijtag_se = 1'b0;
        ijtag_reset = 1'b1;
        chk_out("mid_rst", 1'b0, 3'b000, 1'b0);
        chk_eq("mid_rst_so", 32'(ijtag_so), 32'd0);
        shift_n(8'b0000_1111, L);
        do_update();
        chk_out("idle_shift", 1'b1, 3'b111, 1'b0);

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
        // 1,0,1,1,1 parity ok; 1,0,1,1,0 parity bad.
        do_capture(3'b000);
        shift_n(8'b0001_1101, L);
        do_update();
        chk_out("par_ok", 1'b1, 3'b110, 1'b0);
        do_capture(3'b000);
        shift_n(8'b0000_1001, L);
        do_update();
        chk_out("par_ok2", 1'b1, 3'b100, 1'b0);
        do_capture(3'b000);
        shift_n(8'b0000_1101, L);
        do_update();
        chk_out("par_bad", 1'b1, 3'b100, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/firebird7_in_gate1_tessent_tdr_data_ctrl.md
Name: firebird7_in_gate1_tessent_tdr_data_ctrl

Overview:
- IJTAG test data register (TDR) that drives the select and data inputs of the per-group 3-bit data mux.
- Provides capture/shift/update access to a select bit plus WIDTH override bits, with shift-length checking to block corrupted updates.
- Sits on the gate1 IJTAG scan path in the same parent as the data mux: ijtag_select and ijtag_data_out feed the mux, and functional_data_in is tapped for observation.

Parameters:
- WIDTH, 3, number of override data bits (matches the mux width).
- DATA_RESET, '0, reset value of ijtag_data_out.
- SEL_RESET, 1'b0, reset value of ijtag_select.

Ports:
- ijtag_tck  in  1  TDR clock; single clock domain.
- ijtag_reset  in  1  synchronous, active-low reset.
- ijtag_sel  in  1  TDR selected on the scan path.
- ijtag_ce  in  1  capture enable.
- ijtag_se  in  1  shift enable.
- ijtag_ue  in  1  update enable.
- ijtag_si  in  1  scan in.
- ijtag_so  out  1  scan out.
- functional_data_in  in  WIDTH  functional value, captured for observation.
- ijtag_select  out  1  mux select (update stage).
- ijtag_data_out  out  WIDTH  mux override data (update stage).
- update_error  out  1  sticky flag: last update attempt rejected.

Behaviour:
- Shift register SR has length L = WIDTH+1 (WIDTH+2 with the optional feature).
  - SR[0] = select bit; SR[WIDTH:1] = data bits.
  - ijtag_si enters at SR[L-1]; ijtag_so = SR[0], combinational from the flop.
- Reset (ijtag_reset==0 at the tck edge):
  - SR=0, ijtag_select=SEL_RESET, ijtag_data_out=DATA_RESET.
  - update_error=0, bit_cnt=0, state=IDLE.
  - Reset overrides every enable on the same edge, including mid-shift.
- All operations require ijtag_sel=1. With ijtag_sel=0, everything holds except reset.
- Priority per edge: ce > se > ue.
  - ue is ignored in any cycle where ce or se is also high.
  - ce and se together: capture wins, no shift.
- FSM states: IDLE, CAPTURED, SHIFTING, OVERRUN.
  - Capture: SR <= {functional_data_in, ijtag_select}. Sets bit_cnt=0 and state=CAPTURED, from any state.
  - Shift: SR <= {ijtag_si, SR[L-1:1]}.
    - bit_cnt increments and saturates at L+1.
    - State goes to SHIFTING while bit_cnt+1 <= L, and to OVERRUN when it exceeds L.
    - Shifting from IDLE without a prior capture is allowed and counts normally.
  - Update (ue, no ce/se):
    - If state==SHIFTING and bit_cnt==L: ijtag_select<=SR[0], ijtag_data_out<=SR[WIDTH:1], update_error<=0.
    - Otherwise (short shift, overrun, or no shift): outputs hold and update_error<=1.
    - In both cases bit_cnt=0 and state=IDLE.
- Latency:
  - Outputs change on the edge where ue is sampled.
  - ijtag_so reflects the new SR[0] one edge after a shift or capture.
- update_error stays set until the next successful update or reset.

Optional Feature:
- FIREBIRD7_IN_GATE1_TDR_PARITY_EN.
- Defined:
  - L = WIDTH+2, with SR[L-1] as the even-parity bit.
  - Capture loads parity = XOR of the captured select and data bits.
  - Update additionally requires XOR(SR[L-1:0])==0; a failure sets update_error and holds outputs.
- Undefined: no parity bit, L = WIDTH+1, length check only.

Decomposition:
- Package firebird7_in_gate1_tessent_tdr_pkg contains:
  - the tdr_state_e enum {IDLE, CAPTURED, SHIFTING, OVERRUN};
  - a function tdr_len(width) returning L, honouring the macro;
  - a function even_parity(vector).
- No sub-module. The parent instantiates this block next to firebird7_in_gate1_tessent_data_mux_w3_24 and wires ijtag_select/ijtag_data_out straight into it.

Test Plan:
- Reset: hold ijtag_reset=0 for 2 edges with ce/se/ue toggling -> ijtag_select=0, ijtag_data_out=3'b000, update_error=0, ijtag_so=0.
- Good update (macro off): sel=1, capture, shift si=1,0,1,1 over 4 edges, then ue -> ijtag_select=1, ijtag_data_out=3'b110, update_error=0.
- Capture/observe: functional_data_in=3'b101, ijtag_select=1, capture, then shift 4 -> ijtag_so sequence 1,1,0,1.
- Short shift: capture, 3 shifts, ue -> outputs unchanged, update_error=1. A following correct 4-shift update clears it.
- Overrun plus priority: 5 shifts then ue -> rejected, update_error=1. Also ue together with se -> shift only, no update attempt.
- Macro on (L=5): shift 1,0,1,1,1 (parity ok) -> ijtag_select=1, ijtag_data_out=3'b110. Shift 1,0,1,1,0 -> rejected, update_error=1.
